// File: rtl/glyph_pkg.sv
// -----------------------------------------------------------------------------
// glyph_pkg
// Shared types for the glyph blitter: FSM state encoding, the captured
// character-cell record and the SRAM write-request record.
// Struct widths follow the default cell geometry (8x16, 8-bit colour,
// two pixels per 20-bit-addressed SRAM word).
// Build option: GLYPH_UNDERLINE_EN adds the underline bit to GlyphCell_t.
// -----------------------------------------------------------------------------
package glyph_pkg;

    localparam int unsigned GLYPH_W_DEF      = 8;
    localparam int unsigned GLYPH_H_DEF      = 16;
    localparam int unsigned COLOR_W_DEF      = 8;
    localparam int unsigned PIX_PER_WORD_DEF = 2;
    localparam int unsigned ADDR_W_DEF       = 20;
    localparam int unsigned DW_DEF           = PIX_PER_WORD_DEF * COLOR_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } blit_state_t;

    typedef struct packed {
        logic [GLYPH_W_DEF*GLYPH_H_DEF-1:0] shape;
        logic [COLOR_W_DEF-1:0]             fg;
        logic [COLOR_W_DEF-1:0]             bg;
        logic                               inverse;
`ifdef GLYPH_UNDERLINE_EN
        logic                               underline;
`endif
    } GlyphCell_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DW_DEF-1:0]     data;
    } SramWrReq_t;

endpackage

// File: rtl/glyph_word_packer.sv
// -----------------------------------------------------------------------------
// glyph_word_packer
// Combinational: turns one glyph row plus a word index into one SRAM word.
// Pixel x = wx*PIX_PER_WORD + k lands in bits [k*COLOR_W +: COLOR_W];
// a set shape bit selects fg, a clear bit selects bg.
// Ports:
//   shapeRow  in   GLYPH_W bits of the current row (bit x = pixel x)
//   wx        in   word index within the row
//   fg, bg    in   effective foreground / background colour
//   word      out  packed PIX_PER_WORD*COLOR_W data word
// -----------------------------------------------------------------------------
module glyph_word_packer #(
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned PIX_PER_WORD = 2,
    parameter int unsigned WX_W         = 2
) (
    input  logic [GLYPH_W-1:0]              shapeRow,
    input  logic [WX_W-1:0]                 wx,
    input  logic [COLOR_W-1:0]              fg,
    input  logic [COLOR_W-1:0]              bg,
    output logic [PIX_PER_WORD*COLOR_W-1:0] word
);

    logic [GLYPH_W-1:0] rowShifted;

    // Shift the word's pixels down to bit 0 so the per-pixel selects use constant indices.
    assign rowShifted = shapeRow >> (wx * PIX_PER_WORD);

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
            word[k*COLOR_W +: COLOR_W] = rowShifted[k] ? fg : bg;
        end
    end

endmodule

// File: rtl/glyph_blit_engine.sv
// -----------------------------------------------------------------------------
// glyph_blit_engine
// Writes one GLYPH_W x GLYPH_H character cell into the SRAM framebuffer,
// PIX_PER_WORD pixels per word, left to right then top to bottom.
// Build option: GLYPH_UNDERLINE_EN adds the underline input, which forces
// the bottom row to the effective foreground colour.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a cell (accepted only while ready)
//   shape               cell bitmap, bit y*GLYPH_W+x, 1 = foreground
//   fg, bg, inverse     colours; inverse swaps them for the whole cell
//   underline           (GLYPH_UNDERLINE_EN only) force bottom row to fg
//   base_addr           word address of the cell's top-left word
//   ready               idle, start accepted
//   done                one-cycle pulse after the final write is acked
//   req_valid/addr/data SRAM write request, held until req_ack
//   req_ack             arbiter accepted the write this cycle
// -----------------------------------------------------------------------------
module glyph_blit_engine
    import glyph_pkg::*;
#(
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned GLYPH_H      = 16,
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned PIX_PER_WORD = 2,
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned STRIDE_WORDS = 320
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [GLYPH_W*GLYPH_H-1:0]        shape,
    input  logic [COLOR_W-1:0]                fg,
    input  logic [COLOR_W-1:0]                bg,
    input  logic                              inverse,
`ifdef GLYPH_UNDERLINE_EN
    input  logic                              underline,
`endif
    input  logic [ADDR_W-1:0]                 base_addr,
    output logic                              ready,
    output logic                              done,
    output logic                              req_valid,
    output logic [ADDR_W-1:0]                 req_addr,
    output logic [PIX_PER_WORD*COLOR_W-1:0]   req_data,
    input  logic                              req_ack
);

    localparam int unsigned WORDS_PER_ROW = GLYPH_W / PIX_PER_WORD;
    localparam int unsigned WX_W   = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned Y_W    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam logic [WX_W-1:0]   WX_LAST = WX_W'(WORDS_PER_ROW - 1);
    localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(GLYPH_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(STRIDE_WORDS);

    blit_state_t state, nextState;

    logic [GLYPH_W*GLYPH_H-1:0] cellShape;
    logic [COLOR_W-1:0]         fgEff;
    logic [COLOR_W-1:0]         bgEff;
    logic [WX_W-1:0]            wxCnt;
    logic [Y_W-1:0]             yCnt;
    logic [ADDR_W-1:0]          rowBase;
    logic [ADDR_W-1:0]          addrQ;
    logic [GLYPH_W*GLYPH_H-1:0] shapeShifted;
    logic [GLYPH_W-1:0]         shapeRow;
    logic                       accept;
    logic                       advance;
    logic                       lastWord;
`ifdef GLYPH_UNDERLINE_EN
    logic                       underlineQ;
`endif

    assign accept   = (state == IDLE) && start;
    assign advance  = (state == WRITE) && req_ack;
    assign lastWord = (wxCnt == WX_LAST) && (yCnt == Y_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = WRITE;
            WRITE:   if (req_ack && lastWord) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready     = (state == IDLE);
        done      = (state == DONE);
        req_valid = (state == WRITE);
    end

    // Cell capture, word/row counters and address walk.
    // addrQ is updated alongside the counters so req_addr comes straight from a
    // register; rowBase accumulates one stride per row instead of y*STRIDE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cellShape  <= '0;
            fgEff      <= '0;
            bgEff      <= '0;
            wxCnt      <= '0;
            yCnt       <= '0;
            rowBase    <= '0;
            addrQ      <= '0;
`ifdef GLYPH_UNDERLINE_EN
            underlineQ <= 1'b0;
`endif
        end else if (accept) begin
            cellShape  <= shape;
            fgEff      <= inverse ? bg : fg;
            bgEff      <= inverse ? fg : bg;
            wxCnt      <= '0;
            yCnt       <= '0;
            rowBase    <= base_addr;
            addrQ      <= base_addr;
`ifdef GLYPH_UNDERLINE_EN
            underlineQ <= underline;
`endif
        end else if (advance) begin
            if (wxCnt == WX_LAST) begin
                wxCnt   <= '0;
                yCnt    <= yCnt + 1'b1;
                rowBase <= rowBase + STRIDE;
                addrQ   <= rowBase + STRIDE;
            end else begin
                wxCnt   <= wxCnt + 1'b1;
                addrQ   <= addrQ + 1'b1;
            end
        end
    end

    assign shapeShifted = cellShape >> (yCnt * GLYPH_W);

`ifdef GLYPH_UNDERLINE_EN
    // An all-ones row renders as the effective foreground.
    assign shapeRow = (underlineQ && (yCnt == Y_LAST)) ? '1 : shapeShifted[GLYPH_W-1:0];
`else
    assign shapeRow = shapeShifted[GLYPH_W-1:0];
`endif

    glyph_word_packer #(
        .GLYPH_W      (GLYPH_W),
        .COLOR_W      (COLOR_W),
        .PIX_PER_WORD (PIX_PER_WORD),
        .WX_W         (WX_W)
    ) uPacker (
        .shapeRow (shapeRow),
        .wx       (wxCnt),
        .fg       (fgEff),
        .bg       (bgEff),
        .word     (req_data)
    );

    assign req_addr = addrQ;

endmodule

// File: tb/tb_glyph_blit_engine.sv
// -----------------------------------------------------------------------------
// tb_glyph_blit_engine
// Self-checking bench for glyph_blit_engine (default geometry 8x16, 2 ppw).
// Table of cell vectors; expected writes pushed to a scoreboard at start and
// popped by the write monitor. Build option: GLYPH_UNDERLINE_EN.
// -----------------------------------------------------------------------------
module tb_glyph_blit_engine;

    typedef struct {
        logic [127:0] shape;
        logic [7:0]   fg;
        logic [7:0]   bg;
        logic         inv;
        logic         ul;
        logic [19:0]  base;
        int unsigned  ackPct;
        logic         poke;
        logic [15:0]  expW0;
        logic [15:0]  expLast;
        logic [19:0]  expLastAddr;
    } vec_t;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    localparam int NVEC = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] shape;
    logic [7:0]   fg;
    logic [7:0]   bg;
    logic         inverse;
    logic         underline;
    logic [19:0]  base_addr;
    logic         ready;
    logic         done;
    logic         req_valid;
    logic [19:0]  req_addr;
    logic [15:0]  req_data;
    logic         req_ack;

    vec_t        vecs[NVEC];
    wr_t         sbQ[$];
    logic [19:0] logAddr[0:1023];
    logic [15:0] logData[0:1023];
    int          wrCount  = 0;
    int          doneCnt  = 0;
    int          checkCnt = 0;
    int          passCnt  = 0;
    int unsigned ackPct   = 0;
    logic        holdValid = 1'b0;
    logic [19:0] holdAddr;
    logic [15:0] holdData;

    always #5 clk = ~clk;

    glyph_blit_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shape     (shape),
        .fg        (fg),
        .bg        (bg),
        .inverse   (inverse),
`ifdef GLYPH_UNDERLINE_EN
        .underline (underline),
`endif
        .base_addr (base_addr),
        .ready     (ready),
        .done      (done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ack   (req_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Ack driver: random per cycle, independent of req_valid.
    initial begin
        req_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            req_ack = ($urandom_range(99) < ackPct);
        end
    end

    // Write monitor, sampled mid-cycle: a write happens at the next posedge
    // when valid and ack are both high.
    always @(negedge clk) begin
        if (rst) begin
            holdValid = 1'b0;
        end else begin
            if (req_valid) begin
                if (holdValid) begin
                    chk("stallAddrHeld", 64'(req_addr), 64'(holdAddr));
                    chk("stallDataHeld", 64'(req_data), 64'(holdData));
                end
                if (req_ack) begin
                    if (sbQ.size() == 0) begin
                        chk("scoreboardUnderflow", 64'(1), 64'(0));
                    end else begin
                        wr_t e;
                        e = sbQ.pop_front();
                        chk("writeAddr", 64'(req_addr), 64'(e.a));
                        chk("writeData", 64'(req_data), 64'(e.d));
                    end
                    if (wrCount < 1024) begin
                        logAddr[wrCount] = req_addr;
                        logData[wrCount] = req_data;
                    end
                    wrCount++;
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    holdAddr  = req_addr;
                    holdData  = req_data;
                end
            end else begin
                holdValid = 1'b0;
            end
            if (done) doneCnt++;
        end
    end

    // Reference model: every word of the cell, in issue order.
    task automatic pushCell(input vec_t v);
        for (int y = 0; y < 16; y++) begin
            for (int wx = 0; wx < 4; wx++) begin
                wr_t         e;
                logic [7:0]  fgE;
                logic [7:0]  bgE;
                logic [127:0] t;
                logic        b;
                fgE = v.inv ? v.bg : v.fg;
                bgE = v.inv ? v.fg : v.bg;
                e.a = 20'(32'(v.base) + 32'(y * 320 + wx));
                e.d = '0;
                for (int k = 0; k < 2; k++) begin
                    t = v.shape >> (y * 8 + wx * 2 + k);
                    b = t[0];
`ifdef GLYPH_UNDERLINE_EN
                    if (v.ul && y == 15) b = 1'b1;
`endif
                    e.d = e.d | (16'(b ? fgE : bgE) << (k * 8));
                end
                sbQ.push_back(e);
            end
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("readyBeforeStart", 64'(ready), 64'(1));
    endtask

    task automatic runCell(input int i);
        vec_t v;
        int   startWr;
        int   startDone;
        int   cyc;
        int   doneCyc;
        v = vecs[i];
        ackPct = v.ackPct;
        waitReady();
        pushCell(v);
        startWr   = wrCount;
        startDone = doneCnt;
        shape     = v.shape;
        fg        = v.fg;
        bg        = v.bg;
        inverse   = v.inv;
        underline = v.ul;
        base_addr = v.base;
        start     = 1'b1;
        cyc       = 1;
        doneCyc   = 0;
        while (doneCyc == 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                start     = 1'b0;
                shape     = {$urandom, $urandom, $urandom, $urandom};
                fg        = 8'($urandom);
                bg        = 8'($urandom);
                inverse   = ~v.inv;
                underline = ~v.ul;
                base_addr = 20'($urandom);
                chk("readyLowInWrite", 64'(ready), 64'(0));
                chk("firstReqLatency", 64'(req_valid), 64'(1));
            end
            if (v.poke && cyc >= 12 && cyc < 15) begin
                start     = 1'b1;
                shape     = '0;
                base_addr = 20'h0;
            end else if (cyc == 15) begin
                start = 1'b0;
            end
            if (done) doneCyc = cyc;
        end
        chk("doneSeen", 64'(doneCyc != 0), 64'(1));
        if (v.ackPct == 100) chk("doneCycle", 64'(doneCyc), 64'(66));
        chk("reqValidInDone", 64'(req_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("readyAfterDone", 64'(ready), 64'(1));
        chk("donePulseWidth", 64'(done), 64'(0));
        chk("doneCount", 64'(doneCnt - startDone), 64'(1));
        chk("writeCount", 64'(wrCount - startWr), 64'(64));
        chk("scoreboardDrained", 64'(sbQ.size()), 64'(0));
        if (wrCount - startWr == 64 && wrCount <= 1024) begin
            chk("firstWordData", 64'(logData[startWr]), 64'(v.expW0));
            chk("firstWordAddr", 64'(logAddr[startWr]), 64'(v.base));
            chk("lastWordData", 64'(logData[startWr + 63]), 64'(v.expLast));
            chk("lastWordAddr", 64'(logAddr[startWr + 63]), 64'(v.expLastAddr));
        end
        sbQ.delete();
    endtask

    initial begin
        logic [127:0] cb;
        logic [15:0]  ulLast;
        int           startWr;
        int           startDone;
        int           n;

        cb = '0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++)
                if ((x + y) % 2 == 0) cb = cb | (128'(1) << (y * 8 + x));
`ifdef GLYPH_UNDERLINE_EN
        ulLast = 16'hC3C3;
`else
        ulLast = 16'h3C3C;
`endif
        //           shape        fg     bg     inv   ul    base       ack  poke  w0        last      lastAddr
        vecs[0] = '{{128{1'b1}}, 8'hAA, 8'h11, 1'b0, 1'b0, 20'h00100, 100, 1'b0, 16'hAAAA, 16'hAAAA, 20'h013C3};
        vecs[1] = '{cb,          8'hF0, 8'h0F, 1'b1, 1'b0, 20'h01000, 100, 1'b0, 16'hF00F, 16'h0FF0, 20'h022C3};
        vecs[2] = '{cb,          8'hF0, 8'h0F, 1'b0, 1'b0, 20'h02000, 100, 1'b0, 16'h0FF0, 16'hF00F, 20'h032C3};
        vecs[3] = '{cb,          8'h12, 8'h34, 1'b0, 1'b0, 20'h23456, 70,  1'b1, 16'h3412, 16'h1234, 20'h24719};
        vecs[4] = '{{128{1'b1}}, 8'h55, 8'h00, 1'b0, 1'b0, 20'hFFFFF, 100, 1'b1, 16'h5555, 16'h5555, 20'h012C2};
        vecs[5] = '{128'h0,      8'hC3, 8'h3C, 1'b0, 1'b1, 20'h00500, 100, 1'b0, 16'h3C3C, ulLast,   20'h017C3};

        rst = 1'b1; start = 1'b0; shape = '0; fg = '0; bg = '0;
        inverse = 1'b0; underline = 1'b0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("resetReady", 64'(ready), 64'(1));
        chk("resetDone", 64'(done), 64'(0));
        chk("resetReqValid", 64'(req_valid), 64'(0));
        chk("resetReqAddr", 64'(req_addr), 64'(0));
        chk("resetReqData", 64'(req_data), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) runCell(i);

        // Reset in the middle of a cell, while the engine is on word 5.
        ackPct = 100;
        waitReady();
        pushCell(vecs[0]);
        startWr   = wrCount;
        startDone = doneCnt;
        shape = vecs[0].shape; fg = vecs[0].fg; bg = vecs[0].bg;
        inverse = 1'b0; base_addr = vecs[0].base; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (wrCount - startWr < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midResetReqValid", 64'(req_valid), 64'(0));
        chk("midResetReady", 64'(ready), 64'(1));
        chk("midResetReqAddr", 64'(req_addr), 64'(0));
        chk("midResetDone", 64'(done), 64'(0));
        chk("midResetWrites", 64'(wrCount - startWr), 64'(5));
        sbQ.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("postResetReady", 64'(ready), 64'(1));
        chk("postResetReqValid", 64'(req_valid), 64'(0));
        chk("postResetNoDone", 64'(doneCnt - startDone), 64'(0));
        chk("postResetNoWrites", 64'(wrCount - startWr), 64'(5));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
